// File: rtl/bit_population_counter_stream.sv
// Streaming bit-statistics pipeline: ones / zeros / CLZ / CTZ of a WIDTH-bit word,
// one CHUNK per register stage, valid/ready handshake with a global stall.

module bpc_stage #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int K     = 0,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             advance,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] word_in,
    input  logic [1:0]       op_in,
    input  logic [CW-1:0]    cnt_in,
    input  logic             found_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] word_out,
    output logic [1:0]       op_out,
    output logic [CW-1:0]    cnt_out,
    output logic             found_out
);
    logic [CHUNK-1:0] chunk;
    logic [CW-1:0]    pop;
    logic [CW-1:0]    tz;
    logic [CW-1:0]    cnt_nxt;
    logic             found_nxt;

    always_comb begin
        chunk = word_in[K*CHUNK +: CHUNK];
        pop   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) pop = pop + CW'(1);
        end
        // an empty chunk contributes its full width to the zero run
        tz = CW'(CHUNK);
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) tz = CW'(i);
        end
        cnt_nxt   = cnt_in;
        found_nxt = found_in;
        if (!op_in[1]) begin
            cnt_nxt = cnt_in + pop;
        end else if (!found_in) begin
            cnt_nxt   = cnt_in + tz;
            found_nxt = |chunk;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_out   <= 1'b0;
            word_out  <= '0;
            op_out    <= '0;
            cnt_out   <= '0;
            found_out <= 1'b0;
        end else if (advance) begin
            vld_out   <= vld_in;
            word_out  <= word_in;
            op_out    <= op_in;
            cnt_out   <= cnt_nxt;
            found_out <= found_nxt;
        end
    end
endmodule

module bit_population_counter_stream #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [1:0]               op_i,
    input  logic                     data_val_i,
    output logic                     data_rdy_o,
    output logic [$clog2(WIDTH):0]   data_o,
    output logic [1:0]               op_o,
    output logic                     data_val_o,
    input  logic                     data_rdy_i
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int CW     = $clog2(WIDTH) + 1;

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("bit_population_counter_stream: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][WIDTH-1:0] word_pipe;
    logic [STAGES:0][1:0]       op_pipe;
    logic [STAGES:0][CW-1:0]    cnt_pipe;
    logic [STAGES:0]            found_pipe;
    logic                       advance;
    logic [WIDTH-1:0]           w;

    assign advance    = ~data_val_o | data_rdy_i;
    assign data_rdy_o = advance;

    // zeros become ones for op 01; CLZ becomes CTZ of the reversed word
    always_comb begin
        w = data_i;
        case (op_i)
            2'b01: w = ~data_i;
            2'b10: for (int i = 0; i < WIDTH; i++) w[i] = data_i[WIDTH-1-i];
            default: w = data_i;
        endcase
    end

    assign vld_pipe[0]   = data_val_i;
    assign word_pipe[0]  = w;
    assign op_pipe[0]    = op_i;
    assign cnt_pipe[0]   = '0;
    assign found_pipe[0] = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        bpc_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .K     (k),
            .CW    (CW)
        ) u_stage (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .advance   (advance),
            .vld_in    (vld_pipe[k]),
            .word_in   (word_pipe[k]),
            .op_in     (op_pipe[k]),
            .cnt_in    (cnt_pipe[k]),
            .found_in  (found_pipe[k]),
            .vld_out   (vld_pipe[k+1]),
            .word_out  (word_pipe[k+1]),
            .op_out    (op_pipe[k+1]),
            .cnt_out   (cnt_pipe[k+1]),
            .found_out (found_pipe[k+1])
        );
    end

    assign data_val_o = vld_pipe[STAGES];
    assign data_o     = cnt_pipe[STAGES];
    assign op_o       = op_pipe[STAGES];

    logic unused_tail;
    assign unused_tail = ^{word_pipe[STAGES], found_pipe[STAGES]};
endmodule

// File: tb/tb_bit_population_counter_stream.sv
// Scoreboard bench for bit_population_counter_stream: random/directed beats,
// expected results from a bit-level reference model, decoupled monitor.

module tb_bit_population_counter_stream;
    localparam int W  = 32;
    localparam int C  = 8;
    localparam int S  = W / C;
    localparam int OW = $clog2(W) + 1;

    typedef struct {
        int res;
        int op;
        int cyc;
        bit lat;
        int ph;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  data_i;
    logic [1:0]    op_i;
    logic          val_i, rdy_o, val_o, rdy_i;
    logic [OW-1:0] data_o;
    logic [1:0]    op_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_lat = 0;
    bit   rand_rdy = 0;
    int   phase = 0;
    exp_t q[$];
    exp_t e;
    bit   hold_v = 0;
    logic [OW-1:0] hold_d;
    logic [1:0]    hold_op;
    int   n5 = 0, first5 = 0, last5 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bit_population_counter_stream #(.WIDTH(W), .CHUNK(C)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (data_i),
        .op_i       (op_i),
        .data_val_i (val_i),
        .data_rdy_o (rdy_o),
        .data_o     (data_o),
        .op_o       (op_o),
        .data_val_o (val_o),
        .data_rdy_i (rdy_i)
    );

    function automatic int ref_model(input logic [63:0] d, input int op, input int wd);
        int n = 0;
        case (op)
            0: for (int i = 0; i < wd; i++) if (d[i]) n++;
            1: for (int i = 0; i < wd; i++) if (!d[i]) n++;
            2: while (n < wd && !d[wd-1-n]) n++;
            default: while (n < wd && !d[n]) n++;
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // stimulus side of the scoreboard: record every accepted beat
    always @(negedge clk) begin
        if (rst_n && val_i && rdy_o)
            q.push_back('{ref_model({32'h0, data_i}, int'(op_i), W), int'(op_i), cyc, chk_lat, phase});
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", int'(val_o), 1);
                chk("stall_data", int'(data_o), int'(hold_d));
                chk("stall_op", int'(op_o), int'(hold_op));
            end
            hold_v  = val_o && !rdy_i;
            hold_d  = data_o;
            hold_op = op_o;
            if (val_o && rdy_i) begin
                if (q.size() == 0) begin
                    chk("output_without_beat", int'(val_o), 0);
                end else begin
                    e = q.pop_front();
                    chk("result", int'(data_o), e.res);
                    chk("op_out", int'(op_o), e.op);
                    if (e.lat) chk("latency", cyc - e.cyc, S);
                    if (e.ph == 5) begin
                        if (n5 == 0) first5 = cyc;
                        last5 = cyc;
                        n5++;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rdy_i = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] op);
        bit acc = 0;
        data_i = d;
        op_i   = op;
        val_i  = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            if (rdy_o) acc = 1;
        end
        if (!acc) chk("accept_timeout", int'(acc), 1);
        step();
        val_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && q.size() > 0; k++) step();
        chk("drain", q.size(), 0);
    endtask

    // second and third configurations, free-running with the consumer always ready
    for (genvar g = 0; g < 2; g++) begin : g_aux
        localparam int AW  = (g == 0) ? 16 : 64;
        localparam int AC  = (g == 0) ? 4 : 16;
        localparam int AS  = AW / AC;
        localparam int AOW = $clog2(AW) + 1;

        logic [AW-1:0]  a_d;
        logic [1:0]     a_op;
        logic           a_vi, a_ro, a_vo, a_ri;
        logic [AOW-1:0] a_do;
        logic [1:0]     a_oo;
        logic [63:0]    r64;
        exp_t           aq[$];
        exp_t           ae;
        bit             done = 0;

        bit_population_counter_stream #(.WIDTH(AW), .CHUNK(AC)) dut_aux (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .data_i     (a_d),
            .op_i       (a_op),
            .data_val_i (a_vi),
            .data_rdy_o (a_ro),
            .data_o     (a_do),
            .op_o       (a_oo),
            .data_val_o (a_vo),
            .data_rdy_i (a_ri)
        );

        always @(negedge clk) begin
            if (rst_n) begin
                if (a_vi && a_ro)
                    aq.push_back('{ref_model(64'(a_d), int'(a_op), AW), int'(a_op), cyc, 1'b1, 6});
                if (a_vo && a_ri) begin
                    if (aq.size() == 0) begin
                        chk("aux_output_without_beat", int'(a_vo), 0);
                    end else begin
                        ae = aq.pop_front();
                        chk("aux_result", int'(a_do), ae.res);
                        chk("aux_op", int'(a_oo), ae.op);
                        chk("aux_latency", cyc - ae.cyc, AS);
                    end
                end
            end
        end

        initial begin
            a_vi = 1'b0; a_ri = 1'b1; a_d = '0; a_op = '0;
            wait (rst_n === 1'b1);
            step();
            for (int n = 0; n < 60; n++) begin
                r64  = {$urandom(), $urandom()} & {$urandom(), $urandom()};
                r64  = r64 >> $urandom_range(0, 63);
                if (n % 7 == 0) r64 = (n % 14 == 0) ? 64'h0 : ~64'h0;
                a_d  = r64[AW-1:0];
                a_op = 2'($urandom_range(0, 3));
                a_vi = ($urandom_range(0, 3) != 0);
                step();
            end
            a_vi = 1'b0;
            for (int k = 0; k < 200 && aq.size() > 0; k++) step();
            chk("aux_drain", aq.size(), 0);
            done = 1;
        end
    end

    initial begin
        logic [31:0] pat [3];
        bit aux_ok;
        pat[0] = 32'h0000_0000;
        pat[1] = 32'hFFFF_FFFF;
        pat[2] = 32'h8000_0000;
        rst_n = 1'b0; val_i = 1'b0; rdy_i = 1'b0; data_i = '0; op_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(val_o), 0);
        chk("reset_data", int'(data_o), 0);
        chk("reset_op", int'(op_o), 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", int'(rdy_o), 1);

        // fixed pattern, all four ops
        rdy_i = 1'b1; chk_lat = 1; phase = 2;
        for (int op = 0; op < 4; op++) send(32'h0000_F0F0, 2'(op));
        drain();

        // extremes and single top bit
        phase = 3;
        for (int p = 0; p < 3; p++)
            for (int op = 0; op < 4; op++) send(pat[p], 2'(op));
        drain();

        // random backpressure
        phase = 4; chk_lat = 0; rand_rdy = 1;
        for (int n = 0; n < 20; n++) send($urandom() >> $urandom_range(0, 31), 2'($urandom_range(0, 3)));
        drain();
        rand_rdy = 0;
        step();
        rdy_i = 1'b1;

        // full throughput: back-to-back beats with the consumer always ready
        phase = 5; chk_lat = 1;
        val_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            data_i = $urandom();
            op_i   = 2'($urandom_range(0, 3));
            step();
        end
        val_i = 1'b0;
        drain();
        chk("throughput_count", n5, 100);
        chk("throughput_span", last5 - first5, 99);

        aux_ok = 0;
        for (int k = 0; k < 2000 && !aux_ok; k++) begin
            step();
            aux_ok = g_aux[0].done && g_aux[1].done;
        end
        chk("aux_finished", int'(aux_ok), 1);

        // reset with a stalled, full pipeline
        phase = 1; chk_lat = 0; rdy_i = 1'b0;
        val_i = 1'b1;
        repeat (S + 2) begin
            data_i = $urandom();
            op_i   = 2'($urandom_range(0, 3));
            step();
        end
        chk("pipeline_full", int'(val_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", int'(val_o), 0);
        chk("mid_reset_data", int'(data_o), 0);
        q.delete();
        val_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ready_after_mid_reset", int'(rdy_o), 1);
        rdy_i = 1'b1;
        repeat (2 * S + 4) step();
        chk("no_stale_beat", int'(val_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
